// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } ps2_state_t;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Show-ahead event FIFO: dout always presents the head entry while not empty.
module ps2_evt_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_reg];
  assign level   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ps2_scan_rx.sv
// PS/2 keyboard receiver: pin sync, clock glitch filter, frame FSM with watchdog,
// E0/F0 prefix merge and an event FIFO with a valid/ready head.
module ps2_scan_rx
  import ps2_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int FILT_LEN   = 4,
  parameter int TIMEOUT_US = 2000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          ev_valid,
  input  logic                          ev_ready,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_brk,
  output logic [$clog2(FIFO_DEPTH):0]   ev_level,
  output logic                          err_parity,
  output logic                          err_frame,
  output logic                          err_ovf
);

  localparam int TO_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int WD_W   = $clog2(TO_CYC + 1);
  localparam int FC_W   = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;

  logic [1:0]       clk_sync_reg;
  logic [1:0]       data_sync_reg;
  logic             clk_s;
  logic             data_s;
  logic             filt_reg;
  logic [FC_W-1:0]  filt_cnt_reg;
  logic             fall;

  ps2_state_t       state_reg;
  ps2_state_t       state_next;
  logic [2:0]       bit_cnt_reg;
  logic [7:0]       shift_reg;
  logic             par_reg;
  logic             start_bit_reg;
  logic [WD_W-1:0]  wd_cnt_reg;
  logic             timeout;
  logic             frame_err;
  logic             parity_err;
  logic             byte_ok;

  logic             ext_reg;
  logic             brk_reg;
  ps2_evt_t         evt_reg;
  logic             evt_valid_reg;
  logic             err_parity_reg;
  logic             err_frame_reg;
  logic             err_ovf_reg;

  logic [9:0]       fifo_dout;
  ps2_evt_t         head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;

  assign clk_s  = clk_sync_reg[1];
  assign data_s = data_sync_reg[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_reg  <= 2'b11;
      data_sync_reg <= 2'b11;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
      data_sync_reg <= {data_sync_reg[0], ps2_data};
    end
  end

  // The filtered clock flips on the FILT_LEN-th consecutive differing sample.
  assign fall = filt_reg && !clk_s && (filt_cnt_reg == FC_W'(FILT_LEN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_reg     <= 1'b1;
      filt_cnt_reg <= '0;
    end else if (clk_s == filt_reg) begin
      filt_cnt_reg <= '0;
    end else if (filt_cnt_reg == FC_W'(FILT_LEN - 1)) begin
      filt_reg     <= clk_s;
      filt_cnt_reg <= '0;
    end else begin
      filt_cnt_reg <= filt_cnt_reg + FC_W'(1);
    end
  end

  assign timeout = (state_reg != ST_IDLE) && (wd_cnt_reg == WD_W'(TO_CYC));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt_reg <= '0;
    end else if (state_reg == ST_IDLE || fall) begin
      wd_cnt_reg <= '0;
    end else if (!timeout) begin
      wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // The edge that leaves IDLE carries the start bit; START judges it on the next cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (fall) state_next = ST_START;
      ST_START: state_next = start_bit_reg ? ST_IDLE : ST_DATA;
      ST_DATA:  if (fall && bit_cnt_reg == 3'd7) state_next = ST_PAR;
      ST_PAR:   if (fall) state_next = ST_STOP;
      ST_STOP:  if (fall) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    if (timeout) state_next = ST_IDLE;
  end

  always_comb begin
    frame_err  = timeout;
    parity_err = 1'b0;
    byte_ok    = 1'b0;
    case (state_reg)
      ST_START: if (start_bit_reg) frame_err = 1'b1;
      ST_STOP: begin
        if (fall && !timeout) begin
          if (!data_s)                     frame_err  = 1'b1;
          else if (^{shift_reg, par_reg})  byte_ok    = 1'b1;
          else                             parity_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_bit_reg <= 1'b1;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      par_reg       <= 1'b0;
    end else if (fall) begin
      case (state_reg)
        ST_IDLE: begin
          start_bit_reg <= data_s;
          bit_cnt_reg   <= '0;
        end
        ST_DATA: begin
          shift_reg   <= {data_s, shift_reg[7:1]};
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
        ST_PAR:  par_reg <= data_s;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_reg        <= 1'b0;
      brk_reg        <= 1'b0;
      evt_reg        <= '0;
      evt_valid_reg  <= 1'b0;
      err_parity_reg <= 1'b0;
      err_frame_reg  <= 1'b0;
      err_ovf_reg    <= 1'b0;
    end else begin
      err_frame_reg  <= frame_err;
      err_parity_reg <= parity_err;
      err_ovf_reg    <= evt_valid_reg && fifo_full && !pop;
      evt_valid_reg  <= 1'b0;
      if (frame_err || parity_err) begin
        ext_reg <= 1'b0;
        brk_reg <= 1'b0;
      end else if (byte_ok) begin
        if (shift_reg == PS2_EXT) begin
          ext_reg <= 1'b1;
        end else if (shift_reg == PS2_BRK) begin
          brk_reg <= 1'b1;
        end else begin
          evt_reg       <= '{ext: ext_reg, brk: brk_reg, code: shift_reg};
          evt_valid_reg <= 1'b1;
          ext_reg       <= 1'b0;
          brk_reg       <= 1'b0;
        end
      end
    end
  end

  ps2_evt_fifo #(
    .WIDTH (10),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (evt_valid_reg),
    .pop   (pop),
    .din   (evt_reg),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (ev_level)
  );

  assign head       = fifo_dout;
  assign ev_valid   = !fifo_empty;
  assign pop        = ev_valid && ev_ready;
  // Gate the head so stale or uninitialised storage never shows while empty.
  assign ev_code    = ev_valid ? head.code : 8'h00;
  assign ev_ext     = ev_valid && head.ext;
  assign ev_brk     = ev_valid && head.brk;
  assign err_parity = err_parity_reg;
  assign err_frame  = err_frame_reg;
  assign err_ovf    = err_ovf_reg;

endmodule
